sram_controller: RTL
====================

Name: sram_controller

Overview:
- Bridges the MEM stage's 32-bit data-memory request to an external 16-bit asynchronous SRAM (512 KB, 18-bit address).
- Each 32-bit word is moved as two 16-bit half transfers, low half first, each with programmable wait cycles.
- Drives a ready flag; the top level derives the pipeline freeze from it as freeze = ~ready.
- Sits directly downstream of the MEM stage and replaces its internal array memory.

Parameters:
- WAIT_CYCLES, 2, extra cycles each half-phase is held before sampling or releasing (0..15).
- ADDR_BASE, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  MEM-stage store request.
- rd_en  input  1  MEM-stage load request.
- address  input  32  byte address (ALU result).
- write_data  input  32  store value.
- read_data  output  32  load result, registered.
- ready  output  1  1 = no transaction pending or transaction completing this cycle.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_out  output  16  write data to pad.
- sram_dq_in  input  16  read data from pad.
- sram_dq_oe  output  1  pad output enable.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Behaviour:
- Reset: state IDLE, counter 0, read_data 0, request latches 0, sram_addr 0, sram_dq_oe 0, all *_n strobes 1.
- word_index = (address - ADDR_BASE) >> 2, truncated to 17 bits.
- Out-of-range addresses wrap modulo 512 KB. address[1:0] is ignored.
- sram_addr = {word_index, half}, where half = 0 in LOW and 1 in HIGH.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If rd_en|wr_en, latch word_index, write_data and is_write (= wr_en), clear the counter, and go to LOW.
  - If both enables are high, treat the request as a write.
- LOW / HIGH:
  - The counter increments each cycle.
  - At counter == WAIT_CYCLES: a read latches sram_dq_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH). The counter clears and the state advances (LOW to HIGH, HIGH to DONE).
- DONE: ready = 1 and the next state is IDLE. read_data holds until the next read completes.
- ready = ~(rd_en|wr_en) | (state == DONE). It is combinational, so there is no bubble when idle.
- Latency: a request first seen at cycle t has ready = 1 at cycle t + 2*(WAIT_CYCLES+1) + 1, which is t+7 for the default.
- Strobes during LOW/HIGH: sram_ce_n = 0, sram_ub_n = 0, sram_lb_n = 0.
- Read phases: sram_oe_n = 0 and sram_dq_oe = 0.
- Write phases:
  - sram_dq_oe = 1 and sram_dq_out = the selected half of the latched data.
  - sram_we_n = 0 except on the final cycle of each phase (counter == WAIT_CYCLES). WE therefore rises before the address changes.
- IDLE/DONE: all strobes 1, sram_dq_oe 0. sram_addr holds its last value.
- Inputs are ignored outside IDLE; the latched request governs the transaction.
- A request still asserted in the IDLE cycle after DONE is a new transaction, because the pipeline advanced on the DONE edge.
- rst mid-transaction: return to IDLE next edge and deassert strobes. A partially written word (low half only) is permitted and not rolled back.

Decomposition:
- Shared package holds:
  - state enum (IDLE=0, LOW=1, HIGH=2, DONE=3);
  - SRAM_ADDR_W=18 and SRAM_DATA_W=16;
  - default ADDR_BASE.
- One sub-module, sram_wait_counter: a 4-bit counter with clear and a terminal flag (count == WAIT_CYCLES).

Test Plan:
- Reset, no requests → ready=1, all strobes 1, read_data=0, sram_dq_oe=0.
- wr_en, address=1024, write_data=0xDEADBEEF:
  - sram_addr 0 with dq_out 0xBEEF, then sram_addr 1 with dq_out 0xDEAD;
  - we_n low 2 cycles per phase;
  - ready low 7 cycles, high on 8th.
- rd_en, address=1028, SRAM model holds 0x5678 at addr 2 and 0x1234 at addr 3 → oe_n low, read_data=0x12345678 in DONE, ready high exactly once.
- Back-to-back: store to 1032, then load from 1032 in the next instruction → second transaction starts in IDLE after DONE; read_data=stored value.
- rd_en and wr_en both high, address=1040 → write performed, oe_n stays 1.
- rst asserted during HIGH of a write → next cycle IDLE, strobes 1, dq_oe 0; a subsequent read of 1024 proceeds normally.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit MEM-stage to 16-bit async SRAM bridge.
package sram_controller_pkg;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int WORD_IDX_W        = SRAM_ADDR_W - 1;
    localparam int DEFAULT_ADDR_BASE = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [WORD_IDX_W-1:0]    word_idx;
        logic [2*SRAM_DATA_W-1:0] data;
        logic                     is_write;
    } sram_req_t;

    // Byte address to SRAM word; anything outside the 512 KB window wraps.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] addr,
                                                         input logic [31:0] base);
        return WORD_IDX_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response plus SRAM pad signals; slave is the controller side.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic                   wr_en;
    logic                   rd_en;
    logic [31:0]            address;
    logic [31:0]            write_data;
    logic [31:0]            read_data;
    logic                   ready;

    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_dq_oe;
    logic                   sram_ce_n;
    logic                   sram_oe_n;
    logic                   sram_we_n;
    logic                   sram_ub_n;
    logic                   sram_lb_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Per-phase wait counter; term marks the last cycle of a half transfer.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);
    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= count + 4'd1;
    end

    assign term = (count == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Moves each 32-bit MEM access as two 16-bit SRAM half transfers, low half first.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'(DEFAULT_ADDR_BASE)
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] LOW  = ST_LOW;
    localparam logic [1:0] HIGH = ST_HIGH;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]             state;
    sram_req_t              req;
    logic [31:0]            read_data;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic                   term;
    logic                   active;
    logic                   req_any;

    assign active  = (state == LOW) || (state == HIGH);
    assign req_any = bus.rd_en | bus.wr_en;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) || term),
        .inc  (active),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            read_data <= '0;
            sram_addr <= '0;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    req.word_idx <= word_index(bus.address, ADDR_BASE);
                    req.data     <= bus.write_data;
                    req.is_write <= bus.wr_en;
                    sram_addr    <= {word_index(bus.address, ADDR_BASE), 1'b0};
                    state        <= LOW;
                end
                LOW: if (term) begin
                    if (!req.is_write)
                        read_data[15:0] <= bus.sram_dq_in;
                    sram_addr <= {req.word_idx, 1'b1};
                    state     <= HIGH;
                end
                HIGH: if (term) begin
                    if (!req.is_write)
                        read_data[31:16] <= bus.sram_dq_in;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // WE is released on the last cycle of each phase so it rises before the address moves.
    assign bus.ready       = ~req_any | (state == DONE);
    assign bus.read_data   = read_data;
    assign bus.sram_addr   = sram_addr;
    assign bus.sram_ce_n   = ~active;
    assign bus.sram_ub_n   = ~active;
    assign bus.sram_lb_n   = ~active;
    assign bus.sram_oe_n   = ~(active & ~req.is_write);
    assign bus.sram_we_n   = ~(active & req.is_write & ~term);
    assign bus.sram_dq_oe  = active & req.is_write;
    assign bus.sram_dq_out = (state == HIGH) ? req.data[31:16] : req.data[15:0];

endmodule
